apb_clint: RTL and testbench

Core-local interruptor on the APB bus, sitting beside the RAM as a second APB slave of `core_top`. It owns the 64-bit `mtime` counter, the `mtimecmp` compare register and the optional `msip` software-interrupt bit. It drives the core's `mtime` and `mtimer_int` inputs (and `int_m_soft`), replacing free-running counters and externally driven timer interrupts at system level.

---
 rtl/clint_pkg.sv | 27 ++
 rtl/clint_timer.sv | 51 +++++
 rtl/apb_clint.sv | 129 ++++++++++++
 tb/tb_apb_clint.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// clint_pkg: shared constants and helpers for the APB core-local interruptor.
//   CLINT_MSIP_OFS      byte offset of the msip word
//   CLINT_MTIMECMP_OFS  byte offset of mtimecmp[31:0] (hi word at +4)
//   CLINT_MTIME_OFS     byte offset of mtime[31:0]    (hi word at +4)
//   MTIMECMP_RST        mtimecmp reset value (never fires out of reset)
//   strb_merge()        byte-strobed merge of write data into a 32-bit word
package clint_pkg;

    localparam logic [31:0] CLINT_MSIP_OFS     = 32'h0000_0000;
    localparam logic [31:0] CLINT_MTIMECMP_OFS = 32'h0000_4000;
    localparam logic [31:0] CLINT_MTIME_OFS    = 32'h0000_BFF8;
    localparam logic [63:0] MTIMECMP_RST       = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                r[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/clint_timer.sv
// clint_timer: prescaler plus 64-bit mtime counter.
//   clk, rst_n   clock, asynchronous active-low reset
//   wr_lo/wr_hi  replace mtime[31:0] / mtime[63:32] with strobed wdata
//   wdata, wstrb write data and byte strobes
//   mtime        current timer value
// A write to either half wins over the increment in that cycle and restarts
// the prescaler, so the next increment lands a full TICK_DIV cycles later.
module clint_timer
    import clint_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [63:0] mtime
);

    localparam int            CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          tick;

    // With TICK_DIV=1 the counter sits at 0 and every cycle is a tick.
    assign tick = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            mtime <= '0;
        end else if (wr_lo || wr_hi) begin
            cnt <= '0;
            if (wr_lo) begin
                mtime[31:0] <= strb_merge(mtime[31:0], wdata, wstrb);
            end
            if (wr_hi) begin
                mtime[63:32] <= strb_merge(mtime[63:32], wdata, wstrb);
            end
        end else if (tick) begin
            cnt   <= '0;
            mtime <= mtime + 64'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/apb_clint.sv
// apb_clint: core-local interruptor, zero-wait-state APB slave.
//   clk, rst_n               clock, asynchronous active-low reset
//   psel, penable, pready    APB handshake (pready = psel & penable)
//   paddr, pwrite, pwdata,   APB request; paddr is the byte offset in the CLINT
//   pwstrb
//   prdata, pslverr          APB response, valid during the access phase
//   mtime                    64-bit timer value to the core
//   mtimer_int               registered (mtime >= mtimecmp), level
//   int_m_soft               msip bit 0, level
// Build option: define CLINT_MSIP_EN to implement the msip register at 0x0000.
// Without it 0x0000 is unmapped and int_m_soft is tied low.
module apb_clint
    import clint_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int TICK_DIV = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel,
    input  logic              penable,
    output logic              pready,
    input  logic [ADDR_W-1:0] paddr,
    input  logic              pwrite,
    input  logic [31:0]       pwdata,
    input  logic [3:0]        pwstrb,
    output logic [31:0]       prdata,
    output logic              pslverr,
    output logic [63:0]       mtime,
    output logic              mtimer_int,
    output logic              int_m_soft
);

    logic        access;
    logic        wr_en;
    logic [31:0] addr_ext;
    logic        sel_msip;
    logic        sel_cmp_lo;
    logic        sel_cmp_hi;
    logic        sel_mt_lo;
    logic        sel_mt_hi;
    logic        hit;
    logic [63:0] mtimecmp;

    assign access   = psel & penable;
    assign addr_ext = 32'(paddr);

    // Exact-offset matching also rejects misaligned addresses.
    always_comb begin
        sel_cmp_lo = (addr_ext == CLINT_MTIMECMP_OFS);
        sel_cmp_hi = (addr_ext == CLINT_MTIMECMP_OFS + 32'd4);
        sel_mt_lo  = (addr_ext == CLINT_MTIME_OFS);
        sel_mt_hi  = (addr_ext == CLINT_MTIME_OFS + 32'd4);
`ifdef CLINT_MSIP_EN
        sel_msip   = (addr_ext == CLINT_MSIP_OFS);
`else
        sel_msip   = 1'b0;
`endif
        hit = sel_msip | sel_cmp_lo | sel_cmp_hi | sel_mt_lo | sel_mt_hi;
    end

    assign pready  = access;
    assign pslverr = access & ~hit;
    // A zero strobe is a legal no-op and must not disturb the prescaler.
    assign wr_en   = access & pwrite & hit & (|pwstrb);

    clint_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_lo (wr_en & sel_mt_lo),
        .wr_hi (wr_en & sel_mt_hi),
        .wdata (pwdata),
        .wstrb (pwstrb),
        .mtime (mtime)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtimecmp <= MTIMECMP_RST;
        end else if (wr_en) begin
            if (sel_cmp_lo) begin
                mtimecmp[31:0] <= strb_merge(mtimecmp[31:0], pwdata, pwstrb);
            end
            if (sel_cmp_hi) begin
                mtimecmp[63:32] <= strb_merge(mtimecmp[63:32], pwdata, pwstrb);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtimer_int <= 1'b0;
        end else begin
            mtimer_int <= (mtime >= mtimecmp);
        end
    end

`ifdef CLINT_MSIP_EN
    logic msip;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msip <= 1'b0;
        end else if (wr_en && sel_msip && pwstrb[0]) begin
            msip <= pwdata[0];
        end
    end

    assign int_m_soft = msip;
`else
    assign int_m_soft = 1'b0;
`endif

    always_comb begin
        prdata = '0;
        if (access && !pwrite) begin
            if (sel_cmp_lo) prdata = mtimecmp[31:0];
            if (sel_cmp_hi) prdata = mtimecmp[63:32];
            if (sel_mt_lo)  prdata = mtime[31:0];
            if (sel_mt_hi)  prdata = mtime[63:32];
`ifdef CLINT_MSIP_EN
            if (sel_msip)   prdata = {31'b0, msip};
`endif
        end
    end

endmodule

// File: tb/tb_apb_clint.sv
// tb_apb_clint: directed bench for apb_clint. Two instances (TICK_DIV=1 and 4)
// share the APB request signals but have separate psel. Each APB transfer
// pushes its expected response into a queue; a monitor pops and compares on
// every pready. Timer and interrupt outputs are checked directly at
// hand-counted clock edges (edge n = n-th rising edge after reset release).
module tb_apb_clint;

    typedef struct {
        bit          to4;
        logic [31:0] d;
        bit          e;
        bit          chk_d;
        string       nm;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        psel1;
    logic        psel4;
    logic        penable;
    logic [15:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pwstrb;
    logic        pready1, pready4;
    logic [31:0] prdata1, prdata4;
    logic        pslverr1, pslverr4;
    logic [63:0] mtime1, mtime4;
    logic        mtimer_int1, mtimer_int4;
    logic        int_m_soft1, int_m_soft4;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t mon_e;

    apb_clint #(.ADDR_W(16), .TICK_DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .psel(psel1), .penable(penable),
        .pready(pready1), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
        .pwstrb(pwstrb), .prdata(prdata1), .pslverr(pslverr1),
        .mtime(mtime1), .mtimer_int(mtimer_int1), .int_m_soft(int_m_soft1)
    );

    apb_clint #(.ADDR_W(16), .TICK_DIV(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .psel(psel4), .penable(penable),
        .pready(pready4), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
        .pwstrb(pwstrb), .prdata(prdata4), .pslverr(pslverr4),
        .mtime(mtime4), .mtimer_int(mtimer_int4), .int_m_soft(int_m_soft4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Monitor: every cycle with pready is an APB completion to score.
    always @(negedge clk) begin
        if (rst_n && (pready1 || pready4)) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pready actual=%b%b expected=00", pready1, pready4);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.to4 ? (!pready4 || pready1) : (!pready1 || pready4)) begin
                    failures++;
                    $display("FAIL %s_pready actual=%b%b expected_dut4=%b", mon_e.nm, pready1, pready4, mon_e.to4);
                end
                checks++;
                if ((mon_e.to4 ? pslverr4 : pslverr1) !== mon_e.e) begin
                    failures++;
                    $display("FAIL %s_pslverr actual=%b expected=%b", mon_e.nm,
                             mon_e.to4 ? pslverr4 : pslverr1, mon_e.e);
                end
                if (mon_e.chk_d) begin
                    checks++;
                    if ((mon_e.to4 ? prdata4 : prdata1) !== mon_e.d) begin
                        failures++;
                        $display("FAIL %s_prdata actual=%h expected=%h", mon_e.nm,
                                 mon_e.to4 ? prdata4 : prdata1, mon_e.d);
                    end
                end
            end
        end
    end

    // Called at posedge+1; consumes two rising edges, the write lands on the second.
    task automatic apb(input bit to4, input bit wr, input logic [15:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] exp_d, input bit exp_e, input string nm);
        exp_t e;
        e.to4 = to4; e.d = exp_d; e.e = exp_e; e.chk_d = !wr; e.nm = nm;
        sb.push_back(e);
        paddr = a; pwrite = wr; pwdata = d; pwstrb = s; penable = 1'b0;
        if (to4) psel4 = 1'b1; else psel1 = 1'b1;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1;
        psel1 = 1'b0; psel4 = 1'b0; penable = 1'b0;
        chk({"completed_", nm}, 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic rd(input bit to4, input logic [15:0] a, input logic [31:0] exp_d,
                      input bit exp_e, input string nm);
        apb(to4, 1'b0, a, 32'h0, 4'h0, exp_d, exp_e, nm);
    endtask

    task automatic wr(input bit to4, input logic [15:0] a, input logic [31:0] d,
                      input logic [3:0] s, input bit exp_e, input string nm);
        apb(to4, 1'b1, a, d, s, 32'h0, exp_e, nm);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; psel1 = 1'b0; psel4 = 1'b0; penable = 1'b0;
        paddr = '0; pwrite = 1'b0; pwdata = '0; pwstrb = '0;
        #12;
        chk("rst_mtime", mtime1, 64'd0);
        chk("rst_int", {62'd0, mtimer_int1, int_m_soft1}, 64'd0);
        chk("rst_bus", {31'd0, pready1, pslverr1, prdata1}, 64'd0);
        @(negedge clk) rst_n = 1'b1;

        tick(10);
        chk("idle10_mtime", mtime1, 64'd10);
        chk("idle10_int", {63'd0, mtimer_int1}, 64'd0);
        tick(2);
        chk("div4_12cyc_mtime", mtime4, 64'd3);
        rd(0, 16'h4004, 32'hFFFF_FFFF, 0, "rd_cmp_hi_rst");
        rd(0, 16'hBFF8, 32'd15, 0, "rd_mtime_lo");

        // mtimecmp = 30 written at edge 20; mtime hits 30 at edge 30.
        wr(0, 16'h4004, 32'd0, 4'hF, 0, "wr_cmp_hi0");
        wr(0, 16'h4000, 32'd30, 4'hF, 0, "wr_cmp_lo30");
        tick(10);
        chk("cmp_mtime30", mtime1, 64'd30);
        chk("cmp_int_before", {63'd0, mtimer_int1}, 64'd0);
        tick(1);
        chk("cmp_int_rise", {63'd0, mtimer_int1}, 64'd1);
        wr(0, 16'h4004, 32'd1, 4'hF, 0, "wr_cmp_hi1");
        chk("cmp_int_hold", {63'd0, mtimer_int1}, 64'd1);
        tick(1);
        chk("cmp_int_fall", {63'd0, mtimer_int1}, 64'd0);

        wr(0, 16'hBFFC, 32'd0, 4'hF, 0, "wr_mt_hi0");
        wr(0, 16'hBFF8, 32'hFFFF_FFFE, 4'hF, 0, "wr_mt_lo");
        chk("mt_written", mtime1, 64'h0000_0000_FFFF_FFFE);
        tick(3);
        chk("mt_carry", mtime1, 64'h0000_0001_0000_0001);

        wr(0, 16'hBFFC, 32'hFFFF_FFFF, 4'hF, 0, "wr_mt_hi_ones");
        wr(0, 16'hBFF8, 32'hFFFF_FFFF, 4'hF, 0, "wr_mt_lo_ones");
        chk("mt_all_ones", mtime1, 64'hFFFF_FFFF_FFFF_FFFF);
        tick(1);
        chk("mt_wrap", mtime1, 64'd0);
        chk("wrap_int_lag", {63'd0, mtimer_int1}, 64'd1);
        tick(1);
        chk("wrap_int_fall", {63'd0, mtimer_int1}, 64'd0);

        rd(0, 16'h1234, 32'h0, 1, "rd_unmapped");
        rd(0, 16'h4002, 32'h0, 1, "rd_misaligned");
        wr(0, 16'h4008, 32'h0, 4'hF, 1, "wr_unmapped");
        wr(0, 16'h4001, 32'h0, 4'hF, 1, "wr_misaligned");
        rd(0, 16'h4000, 32'd30, 0, "rd_cmp_lo_kept");

        wr(1, 16'h4000, 32'hAABB_CCDD, 4'b0010, 0, "wr_cmp_strb");
        rd(1, 16'h4000, 32'hFFFF_CCFF, 0, "rd_cmp_strb");
        wr(1, 16'h4004, 32'h0, 4'h0, 0, "wr_zero_strb");
        rd(1, 16'h4004, 32'hFFFF_FFFF, 0, "rd_zero_strb");

        wr(1, 16'hBFF8, 32'd100, 4'hF, 0, "wr_div4_mt");
        chk("div4_mt_written", mtime4, 64'd100);
        tick(3);
        chk("div4_mt_hold", mtime4, 64'd100);
        tick(1);
        chk("div4_mt_inc", mtime4, 64'd101);

`ifdef CLINT_MSIP_EN
        wr(0, 16'h0000, 32'hFFFF_FFFF, 4'hF, 0, "wr_msip");
        chk("msip_same_edge", {63'd0, int_m_soft1}, 64'd1);
        rd(0, 16'h0000, 32'd1, 0, "rd_msip");
        wr(0, 16'h0000, 32'h0, 4'hF, 0, "wr_msip0");
        chk("msip_clear", {63'd0, int_m_soft1}, 64'd0);
        wr(0, 16'h0000, 32'd1, 4'h1, 0, "wr_msip1");
        chk("msip_set_again", {63'd0, int_m_soft1}, 64'd1);
`else
        wr(0, 16'h0000, 32'd1, 4'hF, 1, "wr_msip_off");
        chk("msip_off_soft", {63'd0, int_m_soft1}, 64'd0);
        rd(0, 16'h0000, 32'h0, 1, "rd_msip_off");
`endif

        // Asynchronous reset in the middle of a cycle.
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("async_rst_mtime1", mtime1, 64'd0);
        chk("async_rst_mtime4", mtime4, 64'd0);
        chk("async_rst_soft", {63'd0, int_m_soft1}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        rd(0, 16'h4000, 32'hFFFF_FFFF, 0, "rd_cmp_after_rst");

        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
